// File: rtl/keymgr_seq_pkg.sv
// Shared types for the key manager operation sequencer: op codes, response status, FSM states.
package keymgr_seq_pkg;

  typedef enum logic [2:0] {
    OpAdvance  = 3'd0,
    OpGenId    = 3'd1,
    OpGenSwOut = 3'd2,
    OpGenHwOut = 3'd3,
    OpDisable  = 3'd4
  } keymgr_ops_e;

  typedef enum logic [1:0] {
    Ok      = 2'd0,
    Err     = 2'd1,
    Timeout = 2'd2,
    Illegal = 2'd3
  } rsp_status_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRespond = 2'd2
  } seq_state_e;

  localparam int unsigned OpW = 3;

  // Codes above OpDisable have no meaning to the key manager and are never issued.
  function automatic logic op_is_legal(input logic [OpW-1:0] code);
    return code <= OpDisable;
  endfunction

endpackage

// File: rtl/keymgr_op_fifo.sv
// Command queue: power-of-two ring buffer, head read combinationally, one-cycle flush.
// Pushes are dropped while full or while flushing; pops on empty are ignored.
module keymgr_op_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [Width-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(Depth));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/keymgr_op_sequencer.sv
// Issues queued key manager ops one at a time with a completion timeout; one response per command.
// Command accepted at c -> op_start at c+2; responses are held until rsp_ready, stalling further ops.
module keymgr_op_sequencer
  import keymgr_seq_pkg::*;
#(
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned CntW          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic            flush,
  output logic            op_start,
  output logic [2:0]      op,
  input  logic            op_done,
  input  logic            op_err,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2:0]      rsp_op,
  output logic [1:0]      rsp_status,
  output logic            busy,
  output logic [CntW-1:0] done_cnt
);

  localparam int unsigned TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  seq_state_e     r_state;
  logic           r_op_start;
  logic [OpW-1:0] r_op;
  logic [TW-1:0]  r_tmo;
  logic           r_rsp_valid;
  logic [OpW-1:0] r_rsp_op;
  rsp_status_e    r_rsp_status;
  logic [CntW-1:0] r_done_cnt;

  logic           w_full;
  logic           w_empty;
  logic [OpW-1:0] w_head;
  logic           w_pop;

  assign w_pop = (r_state == StIdle) && !w_empty;

  keymgr_op_fifo #(
    .Depth (FifoDepth),
    .Width (OpW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_dat   (cmd_op),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_op_start   <= 1'b0;
      r_op         <= '0;
      r_tmo        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_op     <= '0;
      r_rsp_status <= Ok;
      r_done_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            if (op_is_legal(w_head)) begin
              r_state    <= StIssue;
              r_op_start <= 1'b1;
              r_op       <= w_head;
              r_tmo      <= '0;
            end else begin
              r_state      <= StRespond;
              r_rsp_valid  <= 1'b1;
              r_rsp_op     <= w_head;
              r_rsp_status <= Illegal;
            end
          end
        end
        StIssue: begin
          // A completion in the same cycle as the timeout takes priority.
          if (op_done) begin
            r_state      <= StRespond;
            r_op_start   <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_op     <= r_op;
            r_rsp_status <= op_err ? Err : Ok;
          end else if (r_tmo == TW'(TimeoutCycles - 1)) begin
            r_state      <= StRespond;
            r_op_start   <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_op     <= r_op;
            r_rsp_status <= Timeout;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        StRespond: begin
          if (rsp_ready) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
            if (r_rsp_status == Ok && r_done_cnt != '1) begin
              r_done_cnt <= r_done_cnt + CntW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = !w_full;
  assign op_start   = r_op_start;
  assign op         = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_op     = r_rsp_op;
  assign rsp_status = r_rsp_status;
  assign done_cnt   = r_done_cnt;
  assign busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_keymgr_op_sequencer.sv
// Bench for keymgr_op_sequencer: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model (command queue + outstanding op + held response).
module tb_keymgr_op_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int CNTW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_op = 3'd0;
  logic            flush = 1'b0;
  logic            op_start;
  logic [2:0]      op;
  logic            op_done;
  logic            op_err;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2:0]      rsp_op;
  logic [1:0]      rsp_status;
  logic            busy;
  logic [CNTW-1:0] done_cnt;

  keymgr_op_sequencer #(
    .FifoDepth     (DEPTH),
    .TimeoutCycles (TMO),
    .CntW          (CNTW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .flush      (flush),
    .op_start   (op_start),
    .op         (op),
    .op_done    (op_done),
    .op_err     (op_err),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_op     (rsp_op),
    .rsp_status (rsp_status),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Responder controls, written only by the main thread.
  int dly       = 3;
  bit err_on    = 1'b0;
  bit rdy_force = 1'b1;
  bit rdy_rand  = 1'b0;
  bit rnd_resp  = 1'b0;
  bit stray     = 1'b0;

  // Key manager side: op_done after a programmable number of op_start-high cycles (-1 = never).
  initial begin
    int hc;
    int rd;
    bit re;
    hc = 0; rd = 0; re = 1'b0;
    op_done = 1'b0; op_err = 1'b0; rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        hc = 0; op_done = 1'b0; op_err = 1'b0; rsp_ready = 1'b0;
      end else begin
        hc = op_start ? hc + 1 : 0;
        if (hc == 1) begin
          if (rnd_resp) begin
            rd = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 6));
            re = ($urandom_range(0, 3) == 0);
          end else begin
            rd = dly;
            re = err_on;
          end
        end
        op_done = (op_start && rd >= 0 && hc == rd + 1) || stray ||
                  (rnd_resp && $urandom_range(0, 40) == 0);
        op_err  = op_done && (re || (rnd_resp && $urandom_range(0, 1) == 1));
        rsp_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_force;
      end
    end
  end

  // Observed transactions, for the directed checks.
  int rise_cyc[$];
  int rise_op[$];
  int hi_len[$];
  int r_ops[$];
  int r_sts[$];

  initial begin
    bit prev_os;
    int rise_t;
    prev_os = 1'b0; rise_t = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_os = 1'b0;
      end else begin
        if (op_start && !prev_os) begin
          rise_cyc.push_back(cyc);
          rise_op.push_back(int'(op));
          rise_t = cyc;
        end
        if (!op_start && prev_os) hi_len.push_back(cyc - rise_t);
        if (rsp_valid && rsp_ready) begin
          r_ops.push_back(int'(rsp_op));
          r_sts.push_back(int'(rsp_status));
        end
        prev_os = op_start;
      end
    end
  end

  // Reference model: pending commands, at most one outstanding op or one held response.
  initial begin
    int  q[$];
    bit  m_out;
    bit  m_held;
    int  m_op, m_t0, m_rop, m_rst, m_cnt, h;
    bit  acc;
    m_out = 0; m_held = 0; m_op = 0; m_t0 = 0; m_rop = 0; m_rst = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_out = 0; m_held = 0; m_op = 0; m_rop = 0; m_rst = 0; m_cnt = 0;
      end else begin
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);
        chk("op_start", op_start, m_out);
        if (m_out) chk("op", op, m_op);
        chk("rsp_valid", rsp_valid, m_held);
        if (m_held) begin
          chk("rsp_op", rsp_op, m_rop);
          chk("rsp_status", rsp_status, m_rst);
        end
        chk("busy", busy, m_out || m_held || q.size() != 0);
        chk("done_cnt", done_cnt, m_cnt);

        acc = cmd_valid && (q.size() < DEPTH);
        if (m_out) begin
          if (op_done) begin
            m_out = 0; m_held = 1; m_rop = m_op; m_rst = op_err ? 1 : 0;
          end else if (cyc - m_t0 == TMO - 1) begin
            m_out = 0; m_held = 1; m_rop = m_op; m_rst = 2;
          end
        end else if (m_held) begin
          if (rsp_ready) begin
            m_held = 0;
            if (m_rst == 0 && m_cnt < (1 << CNTW) - 1) m_cnt++;
          end
        end else if (q.size() != 0) begin
          h = q.pop_front();
          if (h <= 4) begin
            m_out = 1; m_op = h; m_t0 = cyc + 1;
          end else begin
            m_held = 1; m_rop = h; m_rst = 3;
          end
        end
        if (flush) q.delete();
        else if (acc) q.push_back(int'(cmd_op));
      end
    end
  end

  task automatic clear_obs();
    rise_cyc.delete(); rise_op.delete(); hi_len.delete(); r_ops.delete(); r_sts.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting cycle.
  task automatic push(input int opc, output int acc);
    int k;
    k = 0;
    acc = -1;
    cmd_valid = 1'b1;
    cmd_op = 3'(opc);
    while (acc < 0 && k < 200) begin
      @(negedge clk);
      if (cmd_ready) acc = cyc;
      else begin
        @(posedge clk);
        #1;
      end
      k++;
    end
    chk("push_accept", acc >= 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int k;
    k = 0;
    while (r_ops.size() < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_rsp_wait"}, r_ops.size() >= n, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int n, input string nm);
    int k;
    k = 0;
    while (rise_cyc.size() < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_rise_wait"}, rise_cyc.size() >= n, 1);
  endtask

  initial begin
    int acc;
    int k;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op_start", op_start, 0);
    chk("rst_op", op, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_op", rsp_op, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // Single OpAdvance, op_done 3 cycles after op_start rises
    clear_obs();
    dly = 3; rdy_force = 1'b1;
    push(0, acc);
    wait_rise(1, "t1");
    chk("t1_latency", rise_cyc[0] - acc, 2);
    chk("t1_op", rise_op[0], 0);
    wait_rsp(1, "t1");
    chk("t1_rsp_op", r_ops[0], 0);
    chk("t1_rsp_status", r_sts[0], 0);
    chk("t1_high_len", hi_len[0], 4);
    @(negedge clk);
    chk("t1_done_cnt", done_cnt, 1);
    @(posedge clk);
    #1;

    // Four legal ops back to back
    clear_obs();
    dly = 2;
    for (int i = 0; i < 4; i++) push(i, acc);
    wait_rsp(4, "t2");
    chk("t2_rises", rise_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_issue_order", rise_op[i], i);
      chk("t2_rsp_op", r_ops[i], i);
      chk("t2_rsp_status", r_sts[i], 0);
    end
    for (int i = 1; i < 4; i++) chk("t2_gap", rise_cyc[i] - rise_cyc[i-1] >= hi_len[i-1] + 1, 1);
    @(negedge clk);
    chk("t2_done_cnt", done_cnt, 5);
    @(posedge clk);
    #1;

    // Timeout, then a late op_done while idle
    clear_obs();
    dly = -1;
    push(3, acc);
    wait_rsp(1, "t3");
    chk("t3_rsp_op", r_ops[0], 3);
    chk("t3_rsp_status", r_sts[0], 2);
    chk("t3_high_len", hi_len[0], 64);
    stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_late_busy", busy, 0);
    chk("t3_late_op_start", op_start, 0);
    chk("t3_late_rsp_cnt", r_ops.size(), 1);
    chk("t3_done_cnt", done_cnt, 5);
    @(posedge clk);
    #1;

    // Illegal op code
    clear_obs();
    push(6, acc);
    wait_rsp(1, "t4");
    chk("t4_rsp_op", r_ops[0], 6);
    chk("t4_rsp_status", r_sts[0], 3);
    chk("t4_no_start", rise_cyc.size(), 0);

    // Error completion with a stalled response and a queued follower
    clear_obs();
    dly = 2; err_on = 1'b1; rdy_force = 1'b0;
    push(4, acc);
    push(0, acc);
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t5_rsp_wait", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_op", rsp_op, 4);
      chk("t5_hold_status", rsp_status, 1);
      chk("t5_hold_no_start", op_start, 0);
      chk("t5_hold_done_cnt", done_cnt, 5);
      @(negedge clk);
    end
    chk("t5_rises_in_hold", rise_cyc.size(), 1);
    @(posedge clk);
    #1;
    err_on = 1'b0; rdy_force = 1'b1;
    wait_rsp(2, "t5");
    chk("t5_first_status", r_sts[0], 1);
    chk("t5_second_op", r_ops[1], 0);
    chk("t5_second_status", r_sts[1], 0);
    @(negedge clk);
    chk("t5_done_cnt", done_cnt, 6);
    @(posedge clk);
    #1;

    // Flush during the first op's Issue
    clear_obs();
    dly = 10;
    push(1, acc);
    push(2, acc);
    push(3, acc);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_rsp(1, "t6");
    chk("t6_rsp_op", r_ops[0], 1);
    chk("t6_rsp_status", r_sts[0], 0);
    repeat (4) @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_rsp_cnt", r_ops.size(), 1);
    chk("t6_rises", rise_cyc.size(), 1);
    chk("t6_done_cnt", done_cnt, 7);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of Issue
    clear_obs();
    dly = -1;
    push(0, acc);
    wait_rise(1, "t7");
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_op_start", op_start, 0);
    chk("t7_async_busy", busy, 0);
    chk("t7_async_done_cnt", done_cnt, 0);
    chk("t7_async_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic against the model
    rnd_resp = 1'b1; rdy_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 3'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; flush = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 3000);
    chk("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: time %0t, required finish before 2000000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
